// File: rtl/w0rm_peripheral_dma_copy.sv
// ============================================================================
//  Module   : w0rm_peripheral_dma_copy
//  Brief    : Single-outstanding read-then-write copy engine on the W0RM
//             peripheral memory port, with tag matching and response timeout.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module w0rm_peripheral_dma_copy #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int USER_WIDTH  = 32,
    parameter int LEN_WIDTH   = 16,
    parameter int ADDR_STRIDE = 4,
    parameter int TIMEOUT     = 15
) (
    input  logic                  mem_clk,
    input  logic                  mem_rst_n,
    input  logic                  dma_start_i,
    input  logic [ADDR_WIDTH-1:0] dma_src_i,
    input  logic [ADDR_WIDTH-1:0] dma_dst_i,
    input  logic [LEN_WIDTH-1:0]  dma_len_i,
    input  logic                  dma_abort_i,
    output logic                  dma_busy_o,
    output logic                  dma_done_o,
    output logic                  dma_error_o,
    output logic [LEN_WIDTH-1:0]  dma_count_o,
    output logic                  mem_valid_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic [USER_WIDTH-1:0] mem_user_o,
    input  logic                  mem_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic [USER_WIDTH-1:0] mem_user_i
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_WAIT = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

    localparam int                    TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] STRIDE_C = ADDR_WIDTH'(ADDR_STRIDE);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   src_q, src_d;
    logic [ADDR_WIDTH-1:0]   dst_q, dst_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [LEN_WIDTH-1:0]    idx_q, idx_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic                    error_q, error_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    valid_q, valid_d;
    logic                    read_q, read_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [USER_WIDTH-1:0]   user_q, user_d;

    logic                    w_rsp_hit;
    logic                    w_active;
    logic [LEN_WIDTH-1:0]    w_idx_inc;

    function automatic logic [ADDR_WIDTH-1:0] word_addr(
        input logic [ADDR_WIDTH-1:0] base,
        input logic [LEN_WIDTH-1:0]  idx
    );
        return base + ADDR_WIDTH'(idx) * STRIDE_C;
    endfunction

    function automatic logic [USER_WIDTH-1:0] word_tag(
        input logic                 is_wr,
        input logic [LEN_WIDTH-1:0] idx
    );
        return {is_wr, (USER_WIDTH-1)'(idx)};
    endfunction

    // user_q still holds the tag of the request in flight
    assign w_rsp_hit = mem_valid_i && (mem_user_i == user_q);
    assign w_active  = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign w_idx_inc = idx_q + LEN_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        error_d = error_q;
        data_d  = data_q;

        if (w_active && dma_abort_i) begin
            state_d = S_FINISH;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (dma_start_i) begin
                        src_d   = dma_src_i;
                        dst_d   = dma_dst_i;
                        len_d   = dma_len_i;
                        idx_d   = '0;
                        error_d = 1'b0;
                        state_d = (dma_len_i == '0) ? S_FINISH : S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    tmo_d   = TMO_W'(1);
                    state_d = S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (w_rsp_hit) begin
                        data_d  = mem_data_i;
                        state_d = S_WR_REQ;
                    end else if (tmo_q == TMO_LAST) begin
                        error_d = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                S_WR_REQ: begin
                    tmo_d   = TMO_W'(1);
                    state_d = S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (w_rsp_hit) begin
                        idx_d   = w_idx_inc;
                        state_d = (w_idx_inc == len_q) ? S_FINISH : S_RD_REQ;
                    end else if (tmo_q == TMO_LAST) begin
                        error_d = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                S_FINISH: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Bus outputs are registered from the next state so a request appears
    // in the first cycle of its REQ state; address/data/tag hold otherwise.
    always_comb begin
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_FINISH);
        read_d  = (state_d == S_RD_REQ);
        write_d = (state_d == S_WR_REQ);
        valid_d = read_d || write_d;
        addr_d  = addr_q;
        user_d  = user_q;
        if (read_d) begin
            addr_d = word_addr(src_d, idx_d);
            user_d = word_tag(1'b0, idx_d);
        end else if (write_d) begin
            addr_d = word_addr(dst_d, idx_d);
            user_d = word_tag(1'b1, idx_d);
        end
    end

    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            tmo_q   <= '0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            user_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            error_q <= error_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            read_q  <= read_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            user_q  <= user_d;
        end
    end

    assign dma_busy_o  = busy_q;
    assign dma_done_o  = done_q;
    assign dma_error_o = error_q;
    assign dma_count_o = idx_q;
    assign mem_valid_o = valid_q;
    assign mem_read_o  = read_q;
    assign mem_write_o = write_q;
    assign mem_addr_o  = addr_q;
    assign mem_data_o  = data_q;
    assign mem_user_o  = user_q;

endmodule

`default_nettype wire
